// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants and FSM state type for the round-robin
// select-path arbiter (mux_rr_arbiter, rr_pick, mux_rr_arbiter_if).
//   NUM_REQ : number of requesters sharing the 4:1 select path
//   SEL_W   : width of the select / round-robin pointer
//   CNT_W   : width of the per-grant beat counter
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester-side and downstream-side signals of the arbiter.
//   req       : per-requester request (held while requester has data)
//   data_in   : packed lanes, lane i = data_in[i*DATA_W +: DATA_W]
//   out_ready : downstream accepts the beat
//   lock      : burst lock (only honoured when MUX_ARB_LOCK_EN is defined)
//   grant     : one-hot grant, zero when idle
//   sel       : registered select of the granted lane
//   out_valid : beat on out_data is valid
//   out_data  : selected lane
//   ack       : pulse to granted requester on each accepted beat
// modport slave is the arbiter side, master is the requester/downstream side.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic                      out_ready;
  logic                      lock;
  logic [NUM_REQ-1:0]        grant;
  logic [SEL_W-1:0]          sel;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      ack;

  modport slave (
    input  req, data_in, out_ready, lock,
    output grant, sel, out_valid, out_data, ack
  );

  modport master (
    output req, data_in, out_ready, lock,
    input  grant, sel, out_valid, out_data, ack
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index this round
//   any_o : some request is set
//   win_o : first set request searching ptr_i, ptr_i+1, ... (mod NUM_REQ)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   win_o
);
  logic [SEL_W-1:0] idx;

  assign any_o = |req_i;

  // Walk from lowest to highest priority so the closest-to-ptr hit wins last.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + SEL_W'(k);
      if (req_i[idx]) win_o = idx;
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select of a 4:1 data path
// onto one valid/ready channel. A grant is held for up to MAX_BEATS accepted
// beats, then priority rotates past the last owner; each release costs one
// IDLE cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mux_rr_arbiter_if.slave (req/data_in/out_ready/lock in,
//              grant/sel/out_valid/out_data/ack out)
// Optional: MUX_ARB_LOCK_EN -- while lock=1 the beat limit is suppressed and
// the grant is held until the owner drops its request.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BEATS = 4
)(
  input  logic             clk,
  input  logic             rst,
  mux_rr_arbiter_if.slave  bus
);
  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_BEATS);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               any;
  logic [SEL_W-1:0]   win;
  logic               valid, accept, limit_hit;
  logic [CNT_W:0]     cnt_inc;

  rr_pick u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (any),
    .win_o (win)
  );

  assign valid   = (state_q == BUSY) && bus.req[sel_q];
  assign accept  = valid && bus.out_ready;
  // One extra bit so the compare never sees a wrapped count.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

`ifdef MUX_ARB_LOCK_EN
  assign limit_hit = accept && (cnt_inc >= MAX_C) && !bus.lock;
`else
  logic lock_unused;
  assign lock_unused = bus.lock;
  assign limit_hit   = accept && (cnt_inc >= MAX_C);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = BUSY;
          sel_d   = win;
          grant_d = NUM_REQ'(1) << win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!bus.req[sel_q] || limit_hit) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 1'b1;
        end else if (accept) begin
          // Saturate at the limit so a long locked burst cannot wrap.
          cnt_d = (cnt_inc > MAX_C) ? MAX_C[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid;
  assign bus.ack       = accept;
  assign bus.out_data  = bus.data_in[sel_q*DATA_W +: DATA_W];
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DATA_W(DW)) bus ();

  mux_rr_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the path, how many beats they have had, and
  // where the round-robin search starts next time.
  typedef struct {int id; logic [DW-1:0] d;} beat_t;
  beat_t sbq[$];

  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  logic [3:0] e_grant = '0;
  logic [1:0] e_sel   = '0;
  logic       e_valid = 1'b0;
  logic       e_ack   = 1'b0;

  initial forever begin
    bit found, rel, lk;
    @(negedge clk);
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0;
    end
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e_sel   = 2'(m_sel);
    e_valid = (m_owner >= 0) && bus.req[m_owner];
    e_ack   = e_valid && bus.out_ready;
    if (e_ack) sbq.push_back('{m_owner, bus.data_in[m_owner*DW +: DW]});
`ifdef MUX_ARB_LOCK_EN
    lk = bus.lock;
`else
    lk = 1'b0;
`endif
    if (!rst) begin
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++)
          if (!found && bus.req[(m_ptr + k) % 4]) begin
            found = 1'b1;
            m_owner = (m_ptr + k) % 4;
          end
        if (found) begin m_sel = m_owner; m_beats = 0; end
      end else begin
        rel = !bus.req[m_owner];
        if (e_ack) begin
          m_beats++;
          if (m_beats >= MB && !lk) rel = 1'b1;
        end
        if (rel) begin m_ptr = (m_owner + 1) % 4; m_owner = -1; end
      end
    end
  end

  // Monitor: per-cycle outputs vs model, and each accepted beat vs scoreboard.
  initial forever begin
    beat_t it;
    @(negedge clk);
    #1;
    chk("grant", bus.grant, e_grant);
    chk("sel", bus.sel, e_sel);
    chk("out_valid", bus.out_valid, e_valid);
    chk("ack", bus.ack, e_ack);
    if (bus.ack) begin
      if (sbq.size() == 0) chk("sb_unexpected_ack", 1, 0);
      else begin
        it = sbq.pop_front();
        chk("sb_sel", bus.sel, it.id);
        chk("sb_data", bus.out_data, it.d);
      end
    end
  end

  bit force_a5 = 1'b0;

  task automatic cyc(input logic [3:0] r, input logic rdy, input logic lk, input int n);
    for (int i = 0; i < n; i++) begin
      bus.req       = r;
      bus.out_ready = rdy;
      bus.lock      = lk;
      bus.data_in   = $urandom;
      if (force_a5) bus.data_in[1*DW +: DW] = 8'hA5;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] r;
    bus.req = '0; bus.out_ready = 1'b0; bus.lock = 1'b0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ack", bus.ack, 0);
    rst = 1'b0;

    // single requester, lane 1 = A5
    force_a5 = 1'b1;
    cyc(4'b0010, 1, 0, 1);
    chk("single_grant", bus.grant, 4'b0010);
    chk("single_sel", bus.sel, 1);
    chk("single_data", bus.out_data, 8'hA5);
    cyc(4'b0010, 1, 0, 11);
    force_a5 = 1'b0;
    cyc(4'b0000, 1, 0, 2);

    // all requesting
    cyc(4'b1111, 1, 0, 30);
    cyc(4'b0000, 1, 0, 2);

    // backpressure on requester 3
    cyc(4'b1000, 0, 0, 6);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_sel", bus.sel, 3);
    chk("bp_ack", bus.ack, 0);
    cyc(4'b1000, 1, 0, 6);
    cyc(4'b0000, 1, 0, 2);

    // withdrawal after two beats, then wrap to requester 0
    cyc(4'b1000, 1, 0, 3);
    cyc(4'b0000, 1, 0, 1);
    cyc(4'b1001, 1, 0, 1);
    chk("wrap_grant", bus.grant, 4'b0001);
    cyc(4'b1001, 1, 0, 12);
    cyc(4'b0000, 1, 0, 2);

    // reset in the middle of a burst on requester 2
    cyc(4'b0100, 1, 0, 1);
    cyc(4'b0100, 1, 0, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_grant", bus.grant, 0);
    chk("rstmid_valid", bus.out_valid, 0);
    chk("rstmid_ack", bus.ack, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b0001, 1, 0, 1);
    chk("rstmid_regrant", bus.grant, 4'b0001);
    cyc(4'b0001, 1, 0, 5);

`ifdef MUX_ARB_LOCK_EN
    cyc(4'b0000, 1, 0, 2);
    cyc(4'b0001, 1, 1, 12);
    cyc(4'b0001, 1, 0, 3);
`endif

    // randomized traffic with sticky requests and random lock
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      cyc(r, ($urandom_range(3) != 0), $urandom_range(1), 1);
    end

    cyc(4'b0000, 1, 0, 3);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 select path between four requesters and drives a single downstream valid/ready channel.
- Registers the select and one-hot grant, holds the grant for a burst of up to MAX_BEATS transfers, then rotates priority.
- Sits directly in front of the 4:1 select datapath; its sel output is the path's select.

Parameters:
- DATA_W, 1, width of each requester data lane and of out_data.
- MAX_BEATS, 4, maximum accepted transfers per grant before forced release (legal range 1..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-requester request; req[i] held high while requester i has data.
- data_in  input  4*DATA_W  packed lanes; lane i = data_in[i*DATA_W +: DATA_W].
- out_ready  input  1  downstream accepts the beat when high with out_valid.
- lock  input  1  burst lock (used only with MUX_ARB_LOCK_EN, ignored otherwise).
- grant  output  4  one-hot grant, all zero when idle.
- sel  output  2  registered select of the granted lane.
- out_valid  output  1  beat on out_data is valid.
- out_data  output  DATA_W  data_in lane selected by sel, combinational from registered sel.
- ack  output  1  one-cycle pulse to the granted requester on each accepted beat (out_valid & out_ready).

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, sel=0, out_valid=0, ack=0, ptr=0, beat_cnt=0. out_data then equals lane 0 (don't-care).
- State machine: IDLE and BUSY.
- IDLE:
  - If req is nonzero, pick the first set bit searching ptr, ptr+1, ... mod 4.
  - Next cycle: sel=winner, grant=1<<winner, beat_cnt=0, state=BUSY.
  - If req is zero, stay in IDLE.
  - Latency from req rising to out_valid is exactly 1 cycle.
- BUSY:
  - out_valid = req[sel]; ack = out_valid & out_ready.
  - On each accepted beat, beat_cnt increments.
  - Release occurs when req[sel] is low, or when an accepted beat makes beat_cnt reach MAX_BEATS.
  - On release, the next cycle is: state=IDLE, grant=0, ptr=sel+1 mod 4 (wraps 3 to 0).
  - Each release costs exactly one IDLE bubble cycle.
- Stall: if out_ready is low, out_valid stays high and sel and data stay stable. No timeout.
- Requester withdrawal: if req[sel] drops while out_valid is high and out_ready is low, there is no transfer and the arbiter releases. Requesters must not drop req mid-beat if they need the beat delivered.
- Simultaneous events:
  - A new req arriving on the release cycle is seen in IDLE next cycle.
  - Priority always uses the updated ptr.
- Starvation: with all four requesting continuously, the order is strictly 0,1,2,3,0,... and each burst is MAX_BEATS beats.
- beat_cnt is 8 bits; it compares with MAX_BEATS and never wraps because release resets it.
- Reset mid-burst: all outputs go to their reset values immediately; no beat is acked afterward.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- With the macro defined:
  - While lock=1 in BUSY, the MAX_BEATS limit is suppressed and beat_cnt saturates at MAX_BEATS.
  - Release happens only when req[sel] drops.
  - lock is sampled every cycle. Deasserting lock with beat_cnt >= MAX_BEATS releases after the next accepted beat, or immediately if req[sel] is low.
- Without the macro: the lock port exists but is ignored. Behaviour is exactly as above.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=4, SEL_W=2, CNT_W=8;
  - the state typedef enum {IDLE, BUSY}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, win[1:0].
  - Instantiated once by mux_rr_arbiter.

Test Plan:
- Reset mid-burst: assert rst while BUSY with grant=0100 -> same cycle grant=0, out_valid=0, ack=0. After release, req=0001 -> grant=0001 (ptr back at 0).
- Single requester: req=0010, out_ready=1, MAX_BEATS=4, DATA_W=8, lane1=8'hA5:
  - cycle 1: grant=0010, sel=1, out_data=A5;
  - 4 acks, then 1 idle cycle, then re-grant to 1.
- All requesting, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001, each held 4 beats with a one-cycle gap.
- Backpressure: req=1000, out_ready=0 for 5 cycles -> out_valid=1, sel=3 stable, ack=0, beat_cnt=0. Then out_ready=1 -> 4 acks, then release.
- Withdrawal and wrap: grant on requester 3, req[3] dropped after 2 beats -> release, ptr=0. req=1001 next -> grant=0001.
- MUX_ARB_LOCK_EN with lock=1, req=0001 held for 10 beats -> 10 acks without release. lock=0 -> release after the next ack, grant=0.
